reg_file_2r1w: RTL and testbench
================================

Name: reg_file_2r1w

Overview:
- 32-entry general-purpose register file for the single-cycle RISC datapath.
- Sits directly downstream of the 5-bit write-register select mux: consumes its 5-bit destination index, plus the write-back data and the register-write enable from the control unit.
- Supplies the two source operands (rs, rt) to the ALU operand muxes.
- Also has a debug read port so the bench and the board display can inspect any register.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, index width; depth is 2**ADDR_W.
- ZERO_R0, 1, when 1, register 0 always reads zero and writes to it are dropped.
- BYPASS, 1, when 1, a read of the address being written in the same cycle returns the incoming write data.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- rd_addr_a, input, ADDR_W, source register A index (rs).
- rd_addr_b, input, ADDR_W, source register B index (rt).
- rd_data_a, output, DATA_W, operand A.
- rd_data_b, output, DATA_W, operand B.
- wr_en, input, 1, register-write enable from the control unit.
- wr_addr, input, ADDR_W, destination index from the write-register select mux.
- wr_data, input, DATA_W, write-back value.
- dbg_addr, input, ADDR_W, debug read index.
- dbg_data, output, DATA_W, debug read value.
- wr_count, output, 16, count of committed writes; saturates.

Behaviour:
- Storage: 2**ADDR_W registers of DATA_W bits, plus a 16-bit write counter.
- Reset:
  - rst_n low immediately clears every register and wr_count to 0, with no clock needed.
  - While rst_n is low, all read outputs are 0 and writes are ignored.
  - Deassertion is not synchronised inside the block; the top level supplies a synchronised release.
- Write:
  - On a rising clk edge with rst_n high and wr_en = 1, mem[wr_addr] <= wr_data.
  - Write latency is one cycle: the new value is visible at the storage output from the following cycle.
  - If ZERO_R0 = 1 and wr_addr = 0, the write is dropped and wr_count does not increment.
- Write counter:
  - Increments by 1 on every committed write.
  - Holds at 16'hFFFF and does not wrap.
- Read ports A, B and debug:
  - Combinational, zero latency.
  - Each output is mem[addr], with two overrides, applied in priority order:
    1. If ZERO_R0 = 1 and addr = 0, the output is 0 regardless of anything else, including bypass.
    2. Else, if BYPASS = 1, wr_en = 1 and addr = wr_addr, the output is wr_data. This is the same-cycle write-through, used by the single-cycle write-back.
  - Otherwise the output is the stored value.
- The debug port follows the same bypass and zero rules as ports A and B.
- Simultaneous accesses:
  - A, B and debug may all address the same register at once; every port returns an identical value.
  - Read and write to the same address in one cycle follows the bypass rule above.
  - If BYPASS = 0, that read returns the old value.
- Reset mid-operation: an asynchronous assert between edges clears the array even if a write is pending; no partial write survives.
- Address width: addresses are full ADDR_W values with no out-of-range case; no X propagation from unwritten entries after reset.

Test Plan:
- Reset: preload r5 = 32'hDEADBEEF, pulse rst_n low mid-cycle -> rd_data_a with rd_addr_a = 5 reads 0 immediately and wr_count = 0, without waiting for a clk edge.
- Basic write/read: write r31 = 32'h0000_1234 (link register via the mux's 2'b11 path), next cycle read A = 31 and B = 31 -> both give 32'h1234, wr_count = 1.
- Zero register: ZERO_R0 = 1, write r0 = 32'hFFFF_FFFF -> A = 0 reads 0 and wr_count is unchanged. Repeat with ZERO_R0 = 0 -> A reads 32'hFFFF_FFFF.
- Bypass: r7 holds 32'h11, with wr_en = 1, wr_addr = 7, wr_data = 32'h22 and rd_addr_a = 7 in the same cycle -> rd_data_a = 32'h22 before the edge. With BYPASS = 0 it reads 32'h11, then 32'h22 after the edge.
- Sweep: write r(i) = i*32'h01010101 for i = 1..31, then read every address on A, B and debug -> all match, and r0 = 0.
- Counter saturation: force 65 540 writes to r3 -> wr_count stops at 16'hFFFF and does not wrap to 0.

Source files
------------

// File: rtl/reg_file_2r1w.sv
// rtl/reg_file_2r1w.sv - 32-entry two-read one-write register file with debug port and write counter
module reg_file_2r1w #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [15:0]       wr_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              commit;

    // Writes aimed at the hardwired zero register never reach storage or the counter.
    assign commit = wr_en && !((ZERO_R0 != 0) && (wr_addr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_count <= '0;
        end else if (commit) begin
            mem[wr_addr] <= wr_data;
            if (wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

    // Priority: reset forces zero, then the r0 rule, then same-cycle write-through.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              live,
        input logic              we,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd
    );
        if (!live) begin
            return '0;
        end
        if ((ZERO_R0 != 0) && (addr == '0)) begin
            return '0;
        end
        if ((BYPASS != 0) && we && (addr == wa)) begin
            return wd;
        end
        return stored;
    endfunction

    assign rd_data_a = read_port(rd_addr_a, mem[rd_addr_a], rst_n, wr_en, wr_addr, wr_data);
    assign rd_data_b = read_port(rd_addr_b, mem[rd_addr_b], rst_n, wr_en, wr_addr, wr_data);
    assign dbg_data  = read_port(dbg_addr,  mem[dbg_addr],  rst_n, wr_en, wr_addr, wr_data);

endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb/tb_reg_file_2r1w.sv - checks both the default (zero r0, bypass) and plain (no zero, no bypass) variants
module tb_reg_file_2r1w;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rd_addr_a, rd_addr_b, dbg_addr, wr_addr;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] ra [2];
    logic [31:0] rb [2];
    logic [31:0] rdbg [2];
    logic [15:0] wc [2];

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mm [2][32];
    int          cnt [2];

    always #5 clk = ~clk;

    reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(ra[0]), .rd_data_b(rb[0]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dbg_addr(dbg_addr), .dbg_data(rdbg[0]), .wr_count(wc[0])
    );

    reg_file_2r1w #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(0), .BYPASS(0)) dut_plain (
        .clk(clk), .rst_n(rst_n),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(ra[1]), .rd_data_b(rb[1]),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .dbg_addr(dbg_addr), .dbg_data(rdbg[1]), .wr_count(wc[1])
    );

    // Reference model: variant 0 has zero-r0 and bypass, variant 1 has neither.
    function automatic logic [31:0] model_read(input int k, input logic [4:0] addr);
        if (!rst_n) return 32'h0;
        if (k == 0 && addr == 5'd0) return 32'h0;
        if (k == 0 && wr_en && addr == wr_addr) return wr_data;
        return mm[k][addr];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0;
            for (int i = 0; i < 32; i++) mm[k][i] = 32'h0;
        end
    endtask

    task automatic step();
        for (int k = 0; k < 2; k++) begin
            if (rst_n && wr_en && !(k == 0 && wr_addr == 5'd0)) begin
                mm[k][wr_addr] = wr_data;
                cnt[k] = (cnt[k] < 65535) ? cnt[k] + 1 : 65535;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s.v%0d.a", tag, k), ra[k], model_read(k, rd_addr_a));
            chk($sformatf("%s.v%0d.b", tag, k), rb[k], model_read(k, rd_addr_b));
            chk($sformatf("%s.v%0d.dbg", tag, k), rdbg[k], model_read(k, dbg_addr));
            chk($sformatf("%s.v%0d.cnt", tag, k), {16'h0, wc[k]}, cnt[k][31:0]);
        end
    endtask

    task automatic set_idle();
        wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        rd_addr_a = 5'd0; rd_addr_b = 5'd0; dbg_addr = 5'd0;
        set_idle();
        #2;
        check_all("reset");
        chk("reset.literal", ra[1], 32'h0);
        step();
        rst_n = 1'b1;

        // Preload r5, then assert reset mid-cycle with a write to r6 pending.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        step();
        set_idle(); rd_addr_a = 5'd5;
        check_all("preload");
        chk("preload.literal", ra[0], 32'hDEADBEEF);
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'hCAFEF00D;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst.a", ra[0], 32'h0);
        chk("async_rst.cnt", {16'h0, wc[0]}, 32'h0);
        check_all("in_reset");
        step();
        rst_n = 1'b1;
        set_idle(); rd_addr_a = 5'd5; rd_addr_b = 5'd6;
        check_all("post_reset");

        // Link register write then read on both ports.
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h0000_1234;
        step();
        set_idle(); rd_addr_a = 5'd31; rd_addr_b = 5'd31; dbg_addr = 5'd31;
        check_all("r31");
        chk("r31.literal", rb[0], 32'h1234);
        chk("r31.cnt_literal", {16'h0, wc[0]}, 32'd1);

        // r0 write: dropped on variant 0, stored on variant 1.
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; rd_addr_a = 5'd0;
        check_all("r0_same");
        step();
        set_idle(); rd_addr_a = 5'd0;
        check_all("r0_after");
        chk("r0.zero_literal", ra[0], 32'h0);
        chk("r0.plain_literal", ra[1], 32'hFFFF_FFFF);

        // Bypass on r7.
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11;
        step();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h22; rd_addr_a = 5'd7; rd_addr_b = 5'd7; dbg_addr = 5'd7;
        check_all("bypass_same");
        chk("bypass.on_literal", ra[0], 32'h22);
        chk("bypass.off_literal", ra[1], 32'h11);
        step();
        set_idle();
        check_all("bypass_after");

        // Sweep.
        for (int i = 1; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = i * 32'h01010101;
            step();
        end
        set_idle();
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i); dbg_addr = 5'(i);
            check_all($sformatf("sweep%0d", i));
            step();
        end

        // Random traffic with frequent read/write address collisions.
        for (int n = 0; n < 200; n++) begin
            wr_en = 1'($urandom_range(0, 1));
            wr_addr = 5'($urandom);
            wr_data = $urandom;
            rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            dbg_addr  = ($urandom_range(0, 3) == 0) ? rd_addr_a : 5'($urandom);
            check_all($sformatf("rand%0d", n));
            step();
        end

        // Counter saturation.
        rd_addr_a = 5'd3; rd_addr_b = 5'd1; dbg_addr = 5'd2;
        for (int n = 0; n < 65540; n++) begin
            wr_en = 1'b1; wr_addr = 5'd3; wr_data = $urandom;
            step();
            if (cnt[0] >= 65533 && n < 65536) check_all($sformatf("sat%0d", n));
        end
        set_idle();
        check_all("sat_end");
        chk("sat.literal", {16'h0, wc[0]}, 32'h0000_FFFF);
        chk("sat.plain_literal", {16'h0, wc[1]}, 32'h0000_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
